// File: rtl/efx_fifo_rd_stream.sv
// Read-side adapter for a standard-mode sync FIFO: credit-gated reads feed a small
// skid buffer that is drained over a valid/ready stream, with flush of all held words.
module efx_fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  empty_i,
  output logic                  rd_en_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  flush_i,
  output logic                  busy_o
);

  localparam int BUF_DEPTH = RD_LATENCY + 2;
  localparam int PW        = $clog2(BUF_DEPTH);
  localparam int CW        = $clog2(BUF_DEPTH + 1);

  logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]         occ_reg, occ_next;
  logic [RD_LATENCY-1:0] pipe_reg, pipe_next;
  logic [CW-1:0]         inflight;
  logic [CW:0]           credit_used;
  logic                  capture;
  logic                  pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CW'(pipe_reg[i]);
    end
  end

  // Every issued read already owns a buffer slot, so the buffer cannot overflow
  // regardless of what the consumer does.
  assign credit_used = {1'b0, occ_reg} + {1'b0, inflight};
  assign rd_en_o     = ~empty_i & ~flush_i & ~rst_i & (credit_used < (CW + 1)'(BUF_DEPTH));

  assign capture   = pipe_reg[RD_LATENCY-1] & ~flush_i;
  assign m_valid_o = (occ_reg != '0);
  assign pop       = m_valid_o & m_ready_i;
  assign m_data_o  = buf_mem[rd_ptr_reg];
  assign busy_o    = m_valid_o | (pipe_reg != '0);

  always_comb begin
    pipe_next    = '0;
    pipe_next[0] = rd_en_o;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_next[i] = pipe_reg[i-1];
    end
    wr_ptr_next = capture ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next = pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    occ_next    = occ_reg + CW'(capture) - CW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      occ_reg    <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      pipe_reg   <= '0;
    end else begin
      occ_reg    <= occ_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      pipe_reg   <= pipe_next;
    end
  end

  // Storage is not reset: contents are only visible while occupancy says so.
  always_ff @(posedge clk_i) begin
    if (capture && !rst_i) begin
      buf_mem[wr_ptr_reg] <= rd_data_i;
    end
  end

  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i) occ_reg <= CW'(BUF_DEPTH));
  a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i) !(rd_en_o && empty_i));

endmodule

// File: tb/tb_efx_fifo_rd_stream.sv
// Scoreboard bench for efx_fifo_rd_stream, run at read latency 1 and 2 side by side.
module tb_efx_fifo_rd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  bit done [2];

  task automatic check_val(input string tag, input int lat, input logic [31:0] got, input logic [31:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s lat=%0d got=%0h want=%0h", tag, lat, got, want);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_lat
    localparam int LAT = gi + 1;
    localparam int BD  = LAT + 2;

    logic       rst, empty, rd_en, m_valid, m_ready, flush, busy;
    logic [7:0] rd_data, m_data;

    // External FIFO model with LAT-cycle read latency
    logic [7:0] mem [1024];
    int         head = 0;
    int         tail = 0;
    logic [7:0] dl [LAT];

    assign empty   = (head == tail);
    assign rd_data = dl[LAT-1];

    always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) dl[i] <= dl[i-1];
      if (rd_en) begin
        dl[0] <= mem[head];
        head  <= head + 1;
      end else begin
        dl[0] <= 8'($urandom);
      end
    end

    efx_fifo_rd_stream #(.DATA_WIDTH(8), .RD_LATENCY(LAT)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .empty_i  (empty),
      .rd_en_o  (rd_en),
      .rd_data_i(rd_data),
      .m_valid_o(m_valid),
      .m_ready_i(m_ready),
      .m_data_o (m_data),
      .flush_i  (flush),
      .busy_o   (busy)
    );

    int         cyc = 0, out_cnt = 0, rd_cnt = 0, hs_cnt = 0;
    int         first_rd = -1, first_vld = -1, last_hs = -1, last_busy = -1, gaps = 0;
    bit         consec = 1'b0;
    logic       s_valid, s_busy, s_rd_en;
    logic [7:0] s_data;
    logic [7:0] exp_q [$];

    task automatic load(input int n, input bit rnd);
      logic [7:0] v;
      for (int k = 0; k < n; k++) begin
        v = rnd ? 8'($urandom) : 8'(k);
        mem[tail] = v;
        tail++;
        exp_q.push_back(v);
      end
    endtask

    // One clock: sample at negedge, score, return just after the next posedge
    task automatic step();
      logic [7:0] w;
      @(negedge clk);
      cyc++;
      s_valid = m_valid;
      s_busy  = busy;
      s_rd_en = rd_en;
      s_data  = m_data;
      if (busy) last_busy = cyc;
      if (rd_en) begin
        rd_cnt++;
        out_cnt++;
        if (first_rd < 0) first_rd = cyc;
        check_val("rd_when_empty", LAT, empty, 0);
        check_val("credit_ok", LAT, out_cnt <= BD, 1);
      end
      if (m_valid && m_ready) begin
        hs_cnt++;
        out_cnt--;
        if (first_vld < 0) first_vld = cyc;
        if (consec && last_hs >= 0 && cyc != last_hs + 1) gaps++;
        last_hs = cyc;
        check_val("word_expected", LAT, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          $display("lat=%0d cyc=%0d word %02h expect %02h", LAT, cyc, m_data, w);
          check_val("data", LAT, m_data, w);
        end
      end
      if (flush || rst) begin
        for (int k = 0; k < out_cnt; k++) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        out_cnt = 0;
      end
      @(posedge clk);
      #1;
    endtask

    task automatic drain(input int bound);
      int n = 0;
      while (exp_q.size() != 0 && n < bound) begin
        step();
        n++;
      end
      check_val("drain_done", LAT, exp_q.size(), 0);
    endtask

    initial begin : run
      int h0, r0, n;
      rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
      step();
      check_val("rst_rd_en", LAT, s_rd_en, 0);
      step();
      rst = 1'b0;
      step();
      check_val("reset_valid", LAT, s_valid, 0);
      check_val("reset_busy", LAT, s_busy, 0);

      // Streaming
      m_ready = 1'b1; consec = 1'b1; first_rd = -1; first_vld = -1; last_hs = -1; gaps = 0;
      h0 = hs_cnt;
      load(16, 1'b0);
      n = 0;
      while (hs_cnt - h0 < 16 && n < 200) begin step(); n++; end
      check_val("stream_count", LAT, hs_cnt - h0, 16);
      check_val("first_valid_lat", LAT, first_vld - first_rd, LAT + 1);
      check_val("stream_gaps", LAT, gaps, 0);
      repeat (4) step();
      check_val("stream_idle_busy", LAT, s_busy, 0);

      // Backpressure
      m_ready = 1'b0;
      r0 = rd_cnt;
      load(16, 1'b0);
      repeat (20) begin
        step();
        if (s_valid) check_val("hold_data", LAT, s_data, 0);
      end
      check_val("stall_reads", LAT, rd_cnt - r0, BD);
      check_val("stall_valid", LAT, s_valid, 1);
      m_ready = 1'b1; last_hs = -1; gaps = 0;
      drain(200);
      check_val("bp_gaps", LAT, gaps, 0);
      consec = 1'b0;

      // Random ready
      load(256, 1'b1);
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
        m_ready = 1'($urandom_range(0, 1));
        step();
        n++;
      end
      check_val("random_done", LAT, exp_q.size(), 0);
      m_ready = 1'b1;
      repeat (4) step();

      // Single word
      r0 = rd_cnt; h0 = hs_cnt; first_rd = -1;
      load(1, 1'b0);
      repeat (LAT + 6) step();
      check_val("single_reads", LAT, rd_cnt - r0, 1);
      check_val("single_hs", LAT, hs_cnt - h0, 1);
      check_val("single_busy_end", LAT, last_busy - first_rd, LAT + 1);

      // Flush with a full credit window outstanding
      m_ready = 1'b0; first_rd = -1;
      load(8, 1'b1);
      n = 0;
      while ((first_rd < 0 || cyc < first_rd + LAT + 2) && n < 50) begin step(); n++; end
      check_val("pre_flush_outstanding", LAT, out_cnt, BD);
      flush = 1'b1;
      step();
      check_val("flush_rd_en", LAT, s_rd_en, 0);
      flush = 1'b0;
      step();
      check_val("flush_valid", LAT, s_valid, 0);
      check_val("flush_busy", LAT, s_busy, 0);
      check_val("flush_resume", LAT, s_rd_en, 1);
      m_ready = 1'b1;
      drain(200);

      // Reset mid-stream
      load(16, 1'b0);
      repeat (LAT + 4) step();
      rst = 1'b1;
      step();
      check_val("midrst_rd_en", LAT, s_rd_en, 0);
      rst = 1'b0;
      step();
      check_val("midrst_valid", LAT, s_valid, 0);
      check_val("midrst_busy", LAT, s_busy, 0);
      drain(200);
      repeat (4) step();
      check_val("final_busy", LAT, s_busy, 0);
      done[gi] = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 50000; i++) begin
      if (done[0] && done[1]) break;
      @(posedge clk);
    end
    check_val("lanes_done", 0, {30'd0, done[1], done[0]}, 3);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
